// File: rtl/seq_shift_pkg.sv
// Shared types and constants for the sequential shift unit.
package seq_shift_pkg;

    typedef enum logic [1:0] {
        MODE_LOGIC  = 2'b00,
        MODE_ROT    = 2'b01,
        MODE_ARITH  = 2'b10,
        MODE_SERIAL = 2'b11
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational single-position shift: left moves toward MSB, right toward LSB.
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted,
    output logic             out_bit
);

    always_comb begin
        shifted = '0;
        out_bit = 1'b0;
        if (dir == DIR_LEFT) begin
            shifted = {word[WIDTH-2:0], fill};
            out_bit = word[WIDTH-1];
        end else begin
            shifted = {fill, word[WIDTH-1:1]};
            out_bit = word[0];
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-step shift register: parallel load, then amt single-bit steps under a
// start/busy/done handshake in logical, rotate, arithmetic or serial-in mode.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic             dir_r;
    mode_t            mode_r;
    logic             fill;
    logic [WIDTH-1:0] q_next;
    logic             out_next;

    // Fill for the vacated end, taken from the operation's latched controls.
    // Rotate uses the outgoing bit directly from q to keep fill independent of the step output.
    always_comb begin
        fill = 1'b0;
        unique case (mode_r)
            MODE_LOGIC:  fill = 1'b0;
            MODE_ROT:    fill = (dir_r == DIR_LEFT) ? q[WIDTH-1] : q[0];
            MODE_ARITH:  fill = (dir_r == DIR_RIGHT) ? q[WIDTH-1] : 1'b0;
            MODE_SERIAL: fill = sin;
            default:     fill = 1'b0;
        endcase
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .word   (q),
        .dir    (dir_r),
        .fill   (fill),
        .shifted(q_next),
        .out_bit(out_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            q      <= '0;
            sout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            dir_r  <= DIR_LEFT;
            mode_r <= MODE_LOGIC;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load) begin
                        q <= d;
                    end else if (start) begin
                        if (amt == '0) begin
                            done <= 1'b1;
                        end else begin
                            dir_r  <= dir;
                            mode_r <= mode_t'(mode);
                            cnt    <= amt;
                            busy   <= 1'b1;
                            state  <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    q    <= q_next;
                    sout <= out_next;
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=8) with hand-computed expectations.
module tb_seq_shift_unit;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] d;
    logic       start;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] amt;
    logic       sin;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    seq_shift_unit #(
        .WIDTH(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .d    (d),
        .start(start),
        .dir  (dir),
        .mode (mode),
        .amt  (amt),
        .sin  (sin),
        .q    (q),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the next negedge with q updated.
    task automatic do_load(input string tag, input logic [7:0] val);
        load = 1'b1;
        d    = val;
        @(negedge clk);
        load = 1'b0;
        check({tag, "_q"}, 32'(q), 32'(val));
    endtask

    // Starts an operation and follows it to its done cycle, checking latency and result.
    task automatic run_op(input string tag, input logic dir_i, input logic [1:0] mode_i,
                          input logic [3:0] amt_i, input logic sin_i,
                          input logic [7:0] exp_q, input logic exp_sout);
        int unsigned lat;
        int unsigned busy_n;
        start = 1'b1;
        dir   = dir_i;
        mode  = mode_i;
        amt   = amt_i;
        sin   = sin_i;
        @(negedge clk);
        start  = 1'b0;
        dir    = ~dir_i;
        mode   = ~mode_i;
        amt    = 4'd1;
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, lat, 32'(amt_i) + 32'd1);
        check({tag, "_busy_cycles"}, busy_n, 32'(amt_i));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_q"}, 32'(q), 32'(exp_q));
        check({tag, "_sout"}, 32'(sout), 32'(exp_sout));
    endtask

    initial begin
        int unsigned lat;
        int unsigned done_n;
        rst   = 1'b1;
        load  = 1'b0;
        d     = '0;
        start = 1'b0;
        dir   = 1'b0;
        mode  = 2'b00;
        amt   = '0;
        sin   = 1'b0;
        @(negedge clk);
        check("rst_q", 32'(q), 32'h0);
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_load("load_b5", 8'hB5);
        check("load_busy", 32'(busy), 32'd0);
        check("load_done", 32'(done), 32'd0);

        run_op("lsl3", 1'b0, 2'b00, 4'd3, 1'b0, 8'hA8, 1'b1);
        @(negedge clk);
        check("lsl3_done_pulse_len", 32'(done), 32'd0);

        do_load("load_b5b", 8'hB5);
        run_op("ror4", 1'b1, 2'b01, 4'd4, 1'b0, 8'h5B, 1'b0);
        @(negedge clk);
        do_load("load_b5c", 8'hB5);
        run_op("ror8", 1'b1, 2'b01, 4'd8, 1'b0, 8'hB5, 1'b1);
        @(negedge clk);
        check("sout_hold", 32'(sout), 32'd1);

        do_load("load_96", 8'h96);
        run_op("asr2", 1'b1, 2'b10, 4'd2, 1'b0, 8'hE5, 1'b1);
        @(negedge clk);
        do_load("load_ff", 8'hFF);
        run_op("lsr10", 1'b1, 2'b00, 4'd10, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        do_load("load_81", 8'h81);
        run_op("asl1", 1'b0, 2'b10, 4'd1, 1'b0, 8'h02, 1'b1);
        @(negedge clk);

        // Serial fill with load and start pulsed mid-shift.
        do_load("load_00", 8'h00);
        start = 1'b1;
        dir   = 1'b0;
        mode  = 2'b11;
        amt   = 4'd8;
        sin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            if (lat == 3) begin
                load  = 1'b1;
                d     = 8'h00;
                start = 1'b1;
                amt   = 4'd2;
            end else begin
                load  = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        load  = 1'b0;
        start = 1'b0;
        check("ser8_latency", lat, 32'd9);
        check("ser8_q", 32'(q), 32'hFF);
        check("ser8_sout", 32'(sout), 32'd0);
        run_op("ser4_b2b", 1'b0, 2'b11, 4'd4, 1'b0, 8'hF0, 1'b1);
        @(negedge clk);

        // Reset between step edges 2 and 3 of a 5-step operation.
        start = 1'b1;
        dir   = 1'b0;
        mode  = 2'b00;
        amt   = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_q", 32'(q), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sout", 32'(sout), 32'd0);
        #1;
        rst    = 1'b0;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("no_done_after_rst", done_n, 32'd0);
        check("idle_after_rst", 32'(busy), 32'd0);

        do_load("load_3c", 8'h3C);
        run_op("zero_amt", 1'b0, 2'b00, 4'd0, 1'b0, 8'h3C, 1'b0);
        @(negedge clk);
        check("zero_amt_pulse_len", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
